cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of cache ports; port 0 = d-cache, port 1 = i-cache.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: aclk  in  1  clock, rising edge; aresetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports:
- req_valid  in  NPORT  per-port request.
- req_write  in  NPORT  1 = store.
- req_addr  in  NPORT*AW  per-port address; port k at bits [k*AW +: AW].
- req_size  in  2*NPORT  per-port size: 00 = byte, 01 = half, 10 = word.
- req_wdata  in  NPORT*DW  per-port store data.
- req_ready  out  NPORT  one-cycle completion pulse.
- resp_rdata  out  DW  load data, valid while any req_ready bit is high.
- mem_access  out  1  downstream request.
- mem_write  out  1  downstream store.
- mem_addr  out  AW  downstream address.
- mem_size  out  2  downstream size.
- mem_st_data  out  DW  downstream store data.
- mem_ready  in  1  downstream completion.
- mem_data  in  DW  downstream load data.
- grant_id  out  $clog2(NPORT)  port currently owning memory.
- busy  out  1  transaction in flight.

Function
REQ-006 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-007 IDLE: if any req_valid bit is set, SHALL select a winner, register its write/addr/size/wdata and grant_id, and enter BUSY; otherwise stay in IDLE.
REQ-008 mem_access SHALL rise on the cycle after the winning req_valid is sampled (latency 1).
REQ-009 BUSY: mem_access=1; mem_write/addr/size/st_data SHALL be driven only from registered copies and held stable until mem_ready.
REQ-010 BUSY with mem_ready=1: SHALL capture mem_data into resp_rdata and enter DONE.
REQ-011 DONE: SHALL drive req_ready[grant_id]=1 for exactly one cycle with mem_access=0, then return to IDLE (one bubble cycle between transactions).
REQ-012 A requester SHALL hold req_valid and its fields until req_ready. Deassertion during BUSY SHALL NOT abort the transaction; it completes and still pulses req_ready.
REQ-013 mem_ready SHALL be ignored in IDLE and DONE.
REQ-014 New requests arriving in BUSY or DONE SHALL wait; arbitration happens only in IDLE.
REQ-015 busy SHALL be 1 in BUSY and DONE, 0 in IDLE.
REQ-016 At most one req_ready bit SHALL be high in any cycle.

Reset
REQ-017 On aresetn=0, SHALL immediately (asynchronously) go to IDLE and clear: mem_access, mem_write, mem_addr, mem_size, mem_st_data, req_ready, resp_rdata, grant_id, busy, and the round-robin pointer.
REQ-018 Reset mid-transaction SHALL abandon the transaction with no req_ready pulse; arbitration resumes on the first clock edge after aresetn rises.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined: SHALL keep a pointer register. The winner is the first requesting port at or after the pointer, wrapping modulo NPORT. On entering DONE, the pointer SHALL become grant_id+1, with NPORT-1 wrapping to 0.
REQ-020 Without ARB_ROUND_ROBIN_EN: SHALL use fixed priority, lowest index wins; the pointer register SHALL not exist.

Verification
REQ-021 NPORT=2; port1 load addr 0xBFC00000, size 10; memory returns 0x3C080001 after 3 cycles -> mem_access one cycle after req, mem_addr stable, req_ready=2'b10 for one cycle, resp_rdata=0x3C080001.
REQ-022 Ports 0 and 1 request in the same cycle -> fixed mode: port 0 served, then port 1. Round-robin mode with pointer=1: port 1 served first.
REQ-023 Port0 store addr 0x80001000, data 0xDEADBEEF, size 00 -> mem_write=1, mem_st_data=0xDEADBEEF, mem_size=00 held until mem_ready.
REQ-024 aresetn low while BUSY -> same cycle, mem_access=0 and busy=0; no req_ready pulse; after release, a pending request is re-arbitrated and completes normally.
REQ-025 NPORT=4, round-robin, all ports requesting continuously -> grants in order 0,1,2,3,0; the pointer wraps 3->0.
REQ-026 mem_ready pulsed in IDLE, and req_valid dropped mid-BUSY -> no spurious req_ready in IDLE; the dropped transaction still completes with one req_ready pulse.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates NPORT cache ports onto one downstream memory channel, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module cache_mem_arbiter #(
    parameter int NPORT = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int GW   = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NPORT-1:0]    req_valid,
    input  logic [NPORT-1:0]    req_write,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [2*NPORT-1:0]  req_size,
    input  logic [NPORT*DW-1:0] req_wdata,
    output logic [NPORT-1:0]    req_ready,
    output logic [DW-1:0]       resp_rdata,
    output logic                mem_access,
    output logic                mem_write,
    output logic [AW-1:0]       mem_addr,
    output logic [1:0]          mem_size,
    output logic [DW-1:0]       mem_st_data,
    input  logic                mem_ready,
    input  logic [DW-1:0]       mem_data,
    output logic [GW-1:0]       grant_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [GW-1:0] win_id;
`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;
`endif

    logic [AW-1:0] addr_arr  [NPORT];
    logic [1:0]    size_arr  [NPORT];
    logic [DW-1:0] wdata_arr [NPORT];

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign size_arr[gi]  = req_size[gi*2 +: 2];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        // Completion pulse is decoded from the registered grant, so only one bit can ever be set.
        assign req_ready[gi] = (state_q == ST_DONE) && (grant_q == GW'(gi));
    end

    // Scan from the highest candidate down so the first in priority order overwrites last.
    always_comb begin
        logic [GW:0] cand;
        cand   = '0;
        win_id = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = NPORT - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NPORT)) begin
                cand = cand - (GW+1)'(NPORT);
            end
            if (req_valid[cand[GW-1:0]]) begin
                win_id = cand[GW-1:0];
            end
        end
`else
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_id = GW'(i);
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_BUSY;
                    grant_d = win_id;
                    write_d = req_write[win_id];
                    addr_d  = addr_arr[win_id];
                    size_d  = size_arr[win_id];
                    wdata_d = wdata_arr[win_id];
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    rdata_d = mem_data;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (grant_q == GW'(NPORT - 1)) ? '0 : grant_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Downstream fields come only from the registered copies so they stay put while BUSY.
    assign mem_access  = (state_q == ST_BUSY);
    assign busy        = (state_q != ST_IDLE);
    assign mem_write   = write_q;
    assign mem_addr    = addr_q;
    assign mem_size    = size_q;
    assign mem_st_data = wdata_q;
    assign resp_rdata  = rdata_q;
    assign grant_id    = grant_q;

endmodule
